clock_ctrl: RTL
===============

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter TIME_1S, default 50_000_000, clk cycles per second; even, >= 4.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key_mode  input  1  single-cycle pulse (pre-debounced); advances mode.
REQ-005 key_inc  input  1  single-cycle pulse (pre-debounced); increments field under edit.
REQ-006 time_out  output  17  packed time: [16:12] hour 0..23, [11:6] minute 0..59, [5:0] second 0..59; registered.
REQ-007 blank  output  6  per-digit blank, 1 = digit off: [1:0] second lo/hi, [3:2] minute lo/hi, [5:4] hour lo/hi; registered.
REQ-008 mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC; registered.

Function
REQ-009 Second counter SHALL count 0..TIME_1S-1 and wrap; terminal count = "tick".
REQ-010 In RUN, on tick the second SHALL increment; time_out updates on the same edge the counter wraps.
REQ-011 Second 59 + tick SHALL give 0 with minute carry; minute 59 + carry gives 0 with hour carry; hour 23 + carry gives 0; 23:59:59 -> 00:00:00 in one edge.
REQ-012 FSM: key_mode SHALL step RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN; no other transitions.
REQ-013 In any SET state the second counter SHALL be held at 0 and time SHALL not advance; on return to RUN counting restarts from 0 (first tick TIME_1S cycles after the transition edge).
REQ-014 key_inc in SET_HOUR/SET_MIN/SET_SEC SHALL increment only that field, wrapping 23->0 / 59->0 / 59->0 with no carry into other fields; effective on the edge sampling the pulse.
REQ-015 key_inc in RUN SHALL be ignored.
REQ-016 key_mode and key_inc asserted in the same cycle: key_mode SHALL win, key_inc discarded.
REQ-017 Blink: in SET states a half-second counter (0..TIME_1S/2-1) SHALL toggle a blink phase at each wrap; phase 1 blanks both digits of the edited field, all other blank bits 0.
REQ-018 On entry to any SET state, and on every accepted key_inc, blink counter and phase SHALL clear to 0 (field visible).
REQ-019 In RUN, blank SHALL be 6'b000000 and the blink counter held at 0.
REQ-020 time_out fields SHALL never hold out-of-range values.

Reset
REQ-021 While rst_n low: time_out = 0 (00:00:00), blank = 0, mode = RUN, both counters 0, blink phase 0.
REQ-022 Reset asserted mid-operation (any state, any counter value) SHALL take effect immediately without waiting for clk; first tick follows TIME_1S cycles after the first clk edge with rst_n high.

Structure
REQ-023 Shared package SHALL hold: mode encodings, field limits (HOUR_MAX 23, MIN_MAX 59, SEC_MAX 59), time_out bit offsets/widths and blank bit positions.
REQ-024 One sub-module tick_div SHALL implement a parameterised terminal-count divider with synchronous clear/hold input; instantiated twice (TIME_1S and TIME_1S/2).
REQ-025 time_out SHALL drive the existing six-digit display driver's 17-bit time input directly with the same packing.

Verification (TIME_1S = 10)
REQ-026 Reset then 10 cycles -> time_out = 00:00:01, blank = 0, mode = 0; 600 cycles -> 00:01:00.
REQ-027 Set 23:59:59 via SET states, return to RUN, 10 cycles -> 00:00:00 on exactly the 10th edge.
REQ-028 SET_HOUR at hour 23, key_inc -> hour 0, minute/second unchanged; SET_SEC at 59, key_inc -> 0, minute unchanged.
REQ-029 In SET_MIN idle: blank alternates 6'b001100 / 6'b000000 every 5 cycles, starting visible; key_inc mid-blank -> blank 0 next cycle, next toggle 5 cycles later.
REQ-030 In SET_SEC assert key_mode and key_inc together -> mode = RUN, second unchanged; RUN key_inc -> no change.
REQ-031 Assert rst_n low in SET_MIN with blink phase 1 -> outputs immediately 0/0/RUN without a clk edge.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock controller: mode encodings, field limits,
// time_out packing and per-digit blank positions.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  // time_out packing, matching the six-digit display driver input
  localparam int TIME_W   = 17;
  localparam int HOUR_LSB = 12;
  localparam int HOUR_W   = 5;
  localparam int MIN_LSB  = 6;
  localparam int MIN_W    = 6;
  localparam int SEC_LSB  = 0;
  localparam int SEC_W    = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  localparam int BLANK_W       = 6;
  localparam int BLANK_SEC_LO  = 0;
  localparam int BLANK_SEC_HI  = 1;
  localparam int BLANK_MIN_LO  = 2;
  localparam int BLANK_MIN_HI  = 3;
  localparam int BLANK_HOUR_LO = 4;
  localparam int BLANK_HOUR_HI = 5;

  function automatic logic [TIME_W-1:0] pack_time(
    input logic [HOUR_W-1:0] hour,
    input logic [MIN_W-1:0]  minute,
    input logic [SEC_W-1:0]  second
  );
    logic [TIME_W-1:0] t;
    t = '0;
    t[HOUR_LSB +: HOUR_W] = hour;
    t[MIN_LSB  +: MIN_W]  = minute;
    t[SEC_LSB  +: SEC_W]  = second;
    return t;
  endfunction

  // Digits belonging to the field edited in the given mode; none in RUN.
  function automatic logic [BLANK_W-1:0] field_blank(input mode_e m);
    logic [BLANK_W-1:0] b;
    b = '0;
    case (m)
      MODE_SET_HOUR: begin
        b[BLANK_HOUR_LO] = 1'b1;
        b[BLANK_HOUR_HI] = 1'b1;
      end
      MODE_SET_MIN: begin
        b[BLANK_MIN_LO] = 1'b1;
        b[BLANK_MIN_HI] = 1'b1;
      end
      MODE_SET_SEC: begin
        b[BLANK_SEC_LO] = 1'b1;
        b[BLANK_SEC_HI] = 1'b1;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Terminal-count divider: counts 0..TERM-1 and wraps, tick marks the wrap cycle.
// clr holds the count at 0 and suppresses tick.
module tick_div #(
  parameter int TERM = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERM - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    tick     = !clr && (cnt_reg == LAST);
    cnt_next = cnt_reg + 1'b1;
    if (clr || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock with RUN/SET modes: keeps hh:mm:ss from a one-second divider and
// lets the user step each field, blinking the field under edit at 1 Hz.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TIME_1S = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [16:0] time_out,
  output logic [5:0]  blank,
  output logic [1:0]  mode
);

  mode_e mode_reg;
  mode_e mode_next;

  logic [HOUR_W-1:0] hour_reg;
  logic [HOUR_W-1:0] hour_next;
  logic [MIN_W-1:0]  min_reg;
  logic [MIN_W-1:0]  min_next;
  logic [SEC_W-1:0]  sec_reg;
  logic [SEC_W-1:0]  sec_next;

  logic               phase_reg;
  logic               phase_next;
  logic [BLANK_W-1:0] blank_reg;
  logic [BLANK_W-1:0] blank_next;
  logic [BLANK_W-1:0] blank_sel;

  logic sec_clr;
  logic sec_tick;
  logic blink_clr;
  logic blink_tick;
  logic inc_accept;

  tick_div #(
    .TERM(TIME_1S)
  ) u_sec_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sec_clr),
    .tick (sec_tick)
  );

  tick_div #(
    .TERM(TIME_1S / 2)
  ) u_blink_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (blink_clr),
    .tick (blink_tick)
  );

  always_comb begin
    mode_next = mode_reg;
    if (key_mode) begin
      unique case (mode_reg)
        MODE_RUN:      mode_next = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_next = MODE_SET_MIN;
        MODE_SET_MIN:  mode_next = MODE_SET_SEC;
        MODE_SET_SEC:  mode_next = MODE_RUN;
      endcase
    end
  end

  // key_mode takes priority, so a simultaneous key_inc is dropped
  assign inc_accept = key_inc && !key_mode && (mode_reg != MODE_RUN);
  assign sec_clr    = (mode_reg != MODE_RUN);
  assign blink_clr  = (mode_reg == MODE_RUN) || key_mode || inc_accept;

  always_comb begin
    hour_next = hour_reg;
    min_next  = min_reg;
    sec_next  = sec_reg;
    if (mode_reg == MODE_RUN) begin
      if (sec_tick) begin
        if (sec_reg >= SEC_MAX) begin
          sec_next = '0;
          if (min_reg >= MIN_MAX) begin
            min_next  = '0;
            hour_next = (hour_reg >= HOUR_MAX) ? '0 : hour_reg + 1'b1;
          end else begin
            min_next = min_reg + 1'b1;
          end
        end else begin
          sec_next = sec_reg + 1'b1;
        end
      end
    end else if (inc_accept) begin
      // edits wrap within the field and never carry
      case (mode_reg)
        MODE_SET_HOUR: hour_next = (hour_reg >= HOUR_MAX) ? '0 : hour_reg + 1'b1;
        MODE_SET_MIN:  min_next  = (min_reg >= MIN_MAX) ? '0 : min_reg + 1'b1;
        MODE_SET_SEC:  sec_next  = (sec_reg >= SEC_MAX) ? '0 : sec_reg + 1'b1;
        default:       hour_next = hour_reg;
      endcase
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (blink_clr) begin
      phase_next = 1'b0;
    end else if (blink_tick) begin
      phase_next = ~phase_reg;
    end
    blank_sel = field_blank(mode_next);
  end

  // blank is computed from next-state values so it changes on the same edge as the phase
  for (genvar gi = 0; gi < BLANK_W; gi++) begin : g_blank
    assign blank_next[gi] = phase_next & blank_sel[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= MODE_RUN;
      hour_reg  <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      phase_reg <= 1'b0;
      blank_reg <= '0;
    end else begin
      mode_reg  <= mode_next;
      hour_reg  <= hour_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      phase_reg <= phase_next;
      blank_reg <= blank_next;
    end
  end

  assign time_out = pack_time(hour_reg, min_reg, sec_reg);
  assign blank    = blank_reg;
  assign mode     = mode_reg;

endmodule
